// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states,
// and the per-operation context latched when an iterative op is accepted.
package muldiv_sequencer_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

  typedef struct packed {
    md_op_e op;
    logic   res_neg;  // product/quotient must be negated at fixup
    logic   rem_neg;  // remainder takes the dividend's sign
    logic   div0;
  } md_ctx_t;

  function automatic logic op_is_div(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_move(input md_op_e op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
// The sequencer hands in magnitudes and applies signs afterwards.
module muldiv_iter_core
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               Clk,
  input  logic               init,
  input  logic               step,
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc
);

  localparam int DW = 2 * WIDTH;

  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [DW-1:0]    mul_nxt;
  logic [DW-1:0]    div_nxt;

  // Mul: upper half accumulates, whole register shifts right with the carry.
  assign sum     = {1'b0, acc[DW-1:WIDTH]} + {1'b0, b_q};
  assign mul_nxt = acc[0] ? {sum, acc[WIDTH-1:1]}
                          : {1'b0, acc[DW-1:WIDTH], acc[WIDTH-1:1]};

  // Div: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign rem_sh  = {acc[DW-1:WIDTH], acc[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge Clk) begin
    if (init) begin
      acc <= init_val;
      b_q <= b;
    end else if (step) begin
      acc <= div_mode ? div_nxt : mul_nxt;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner for the MIPS core: MULT/MULTU/DIV/DIVU/MADD/MSUB iterate in CALC, then FIXUP
// applies signs and accumulation. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = MD_ITERS
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             ReadHiLo,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int DW = 2 * WIDTH;

  md_state_e        state;
  logic [CW-1:0]    cnt;
  md_ctx_t          ctx;
  logic [WIDTH-1:0] dividend;

  md_op_e           op_in;
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic             skip_calc;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [DW-1:0]    init_val;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    prod;
  logic [DW-1:0]    fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign op_in  = md_op_e'(Op);
  assign accept = (state == ST_IDLE) && Start && !Flush;
  assign a_neg  = op_is_signed(op_in) && OpA[WIDTH-1];
  assign b_neg  = op_is_signed(op_in) && OpB[WIDTH-1];
  assign a_mag  = a_neg ? (~OpA + 1'b1) : OpA;
  assign b_mag  = b_neg ? (~OpB + 1'b1) : OpB;

`ifdef MULDIV_FAST_MUL_EN
  // Multiplies land the full magnitude product in the core and go straight to FIXUP.
  assign skip_calc = !op_is_div(op_in);
  assign init_val  = op_is_div(op_in) ? {{WIDTH{1'b0}}, a_mag}
                                      : {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
  assign skip_calc = 1'b0;
  assign init_val  = {{WIDTH{1'b0}}, a_mag};
`endif

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .Clk      (Clk),
    .init     (accept && !op_is_move(op_in)),
    .step     (state == ST_CALC),
    .div_mode (op_is_div(ctx.op)),
    .init_val (init_val),
    .b        (b_mag),
    .acc      (acc)
  );

  assign Busy  = (state != ST_IDLE);
  assign Stall = Busy && (Start || ReadHiLo);

  assign prod    = ctx.res_neg ? (~acc + 1'b1) : acc;
  assign quo_fix = ctx.res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix = ctx.rem_neg ? (~acc[DW-1:WIDTH] + 1'b1) : acc[DW-1:WIDTH];

  always_comb begin
    fix = prod;
    case (ctx.op)
      OP_MADD: fix = {Hi, Lo} + prod;
      OP_MSUB: fix = {Hi, Lo} - prod;
      OP_DIV, OP_DIVU: begin
        // Divide by zero leaves the dividend in HI untouched by sign fixup.
        if (ctx.div0) fix = {dividend, {WIDTH{1'b1}}};
        else          fix = {rem_fix, quo_fix};
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ctx      <= '0;
      dividend <= '0;
      Hi       <= '0;
      Lo       <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_in == OP_MTHI) begin
              Hi <= OpA;
            end else if (op_in == OP_MTLO) begin
              Lo <= OpA;
            end else begin
              ctx.op      <= op_in;
              ctx.res_neg <= a_neg ^ b_neg;
              ctx.rem_neg <= a_neg;
              ctx.div0    <= op_is_div(op_in) && (OpB == '0);
              dividend    <= OpA;
              cnt         <= '0;
              state       <= skip_calc ? ST_FIXUP : ST_CALC;
            end
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          {Hi, Lo} <= fix;
          Done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized + directed bench for muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MADD = 3'd4, MSUB = 3'd5, MTHI = 3'd6, MTLO = 3'd7;
  localparam int LAT_ITER = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] OpA = '0;
  logic [31:0] OpB = '0;
  logic        ReadHiLo = 1'b0;
  logic        Flush = 1'b0;
  logic        Busy, Stall, Done;
  logic [31:0] Hi, Lo;

  int          total = 0;
  int          bad = 0;
  logic [63:0] m_hl = '0;

  muldiv_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .ReadHiLo(ReadHiLo), .Flush(Flush), .Busy(Busy), .Stall(Stall), .Done(Done),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
    logic signed [63:0] sa, sb, sp, q, r;
    logic [63:0] up, res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sp = sa * sb;
    up = {32'b0, a} * {32'b0, b};
    res = hl;
    case (op)
      MULT:  res = sp;
      MULTU: res = up;
      MADD:  res = hl + sp;
      MSUB:  res = hl - sp;
      DIV: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      DIVU:  res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      MTHI:  res = {a, hl[31:0]};
      default: res = {hl[63:32], a};
    endcase
    return res;
  endfunction

  function automatic bit is_mul(input logic [2:0] op);
    return (op == MULT) || (op == MULTU) || (op == MADD) || (op == MSUB);
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp_hl, pre;
    int lat, exp_lat;
    bit moved;
    pre = m_hl;
    exp_hl = ref_op(op, a, b, m_hl);
    @(negedge Clk); Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge Clk); #1; Start = 1'b0;
    if (op == MTHI || op == MTLO) begin
      total++;
      if ({Hi, Lo} !== exp_hl || Busy !== 1'b0 || Done !== 1'b0) begin
        bad++;
        $display("FAIL move op=%0d: hilo=%h busy=%b done=%b, want hilo=%h busy=0 done=0",
                 op, {Hi, Lo}, Busy, Done, exp_hl);
      end
    end else begin
      exp_lat = is_mul(op) ? LAT_MUL : LAT_ITER;
      lat = 0; moved = 0;
      while (Done !== 1'b1 && lat < 100) begin
        if ({Hi, Lo} !== pre) moved = 1;
        @(posedge Clk); #1; lat++;
      end
      total++;
      if (lat != exp_lat) begin
        bad++; $display("FAIL latency op=%0d: got %0d cycles, want %0d", op, lat, exp_lat);
      end
      total++;
      if ({Hi, Lo} !== exp_hl) begin
        bad++; $display("FAIL result op=%0d a=%h b=%h: hilo=%h, want %h", op, a, b, {Hi, Lo}, exp_hl);
      end
      total++;
      if (moved || Busy !== 1'b0) begin
        bad++; $display("FAIL hilo_early/busy op=%0d: moved=%0d busy=%b, want 0/0", op, moved, Busy);
      end
      @(posedge Clk); #1;
      total++;
      if (Done !== 1'b0) begin
        bad++; $display("FAIL done_pulse op=%0d: done=%b, want 0", op, Done);
      end
    end
    m_hl = exp_hl;
  endtask

  task automatic test_reset();
    bit seen;
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if ({Hi, Lo} !== 64'd0 || Busy !== 1'b0 || Stall !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL reset_state: hilo=%h busy=%b stall=%b done=%b, want all 0",
                      {Hi, Lo}, Busy, Stall, Done);
    end
    @(negedge Clk); Rst = 1'b1;
    m_hl = '0;
    run_op(MTHI, 32'h1234_5678, 32'd0);
    run_op(MTLO, 32'h9ABC_DEF0, 32'd0);
    @(negedge Clk); Start = 1'b1; Op = DIV; OpA = 32'd100; OpB = 32'd7;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk); Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if ({Hi, Lo} !== 64'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL reset_mid_div: hilo=%h busy=%b done=%b, want 0/0/0", {Hi, Lo}, Busy, Done);
    end
    @(negedge Clk); Rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) seen = 1;
    end
    total++;
    if (seen || {Hi, Lo} !== 64'd0) begin
      bad++; $display("FAIL reset_no_done: done_seen=%0d hilo=%h, want 0 and 0", seen, {Hi, Lo});
    end
    m_hl = '0;
  endtask

  task automatic test_directed();
    run_op(MULT, 32'hFFFF_FFFE, 32'd3);
    total++;
    if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
      bad++; $display("FAIL mult_neg: hilo=%h, want ffffffff_fffffffa", {Hi, Lo});
    end
    run_op(MULTU, 32'hFFFF_FFFE, 32'd3);
    total++;
    if ({Hi, Lo} !== 64'h00000002_FFFFFFFA) begin
      bad++; $display("FAIL multu: hilo=%h, want 00000002_fffffffa", {Hi, Lo});
    end
    run_op(DIV, 32'hFFFF_FFF9, 32'd2);
    total++;
    if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      bad++; $display("FAIL div_neg: hilo=%h, want ffffffff_fffffffd", {Hi, Lo});
    end
    run_op(DIVU, 32'd7, 32'd0);
    total++;
    if ({Hi, Lo} !== 64'h00000007_FFFFFFFF) begin
      bad++; $display("FAIL divu_zero: hilo=%h, want 00000007_ffffffff", {Hi, Lo});
    end
    run_op(DIV, 32'hFFFF_FFF7, 32'd0);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    total++;
    if ({Hi, Lo} !== 64'h00000000_80000000) begin
      bad++; $display("FAIL div_ovf: hilo=%h, want 00000000_80000000", {Hi, Lo});
    end
    run_op(MTHI, 32'd0, 32'd0);
    run_op(MTLO, 32'd10, 32'd0);
    run_op(MADD, 32'd4, 32'd5);
    total++;
    if ({Hi, Lo} !== 64'd30) begin
      bad++; $display("FAIL madd: hilo=%h, want 30", {Hi, Lo});
    end
    run_op(MSUB, 32'd4, 32'd5);
    total++;
    if ({Hi, Lo} !== 64'd10) begin
      bad++; $display("FAIL msub: hilo=%h, want 10", {Hi, Lo});
    end
    run_op(MULT, 32'd6, 32'd7);
    total++;
    if ({Hi, Lo} !== 64'd42) begin
      bad++; $display("FAIL mult_6x7: hilo=%h, want 42", {Hi, Lo});
    end
  endtask

  task automatic test_stall_read();
    logic [63:0] exp_hl;
    logic [31:0] a, b;
    int n, guard;
    a = $urandom; b = $urandom_range(1, 5000);
    exp_hl = ref_op(DIV, a, b, m_hl);
    @(negedge Clk); Start = 1'b1; Op = DIV; OpA = a; OpB = b;
    @(posedge Clk); #1; Start = 1'b0;
    @(posedge Clk); #1; ReadHiLo = 1'b1; #1;
    n = 0; guard = 0;
    while (Done !== 1'b1 && guard < 100) begin
      if (Stall === 1'b1) n++;
      @(posedge Clk); #1; guard++;
    end
    total++;
    if (n != 32) begin
      bad++; $display("FAIL stall_count: got %0d stalled cycles, want 32", n);
    end
    total++;
    if (Stall !== 1'b0 || Lo !== exp_hl[31:0]) begin
      bad++; $display("FAIL stall_release: stall=%b lo=%h, want 0 and %h", Stall, Lo, exp_hl[31:0]);
    end
    ReadHiLo = 1'b0;
    m_hl = exp_hl;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp1, exp2;
    logic [31:0] a1, b1, a2, b2;
    int guard, lat;
    bit stall_ok;
    a1 = $urandom; b1 = $urandom_range(1, 300);
    a2 = $urandom; b2 = $urandom;
    exp1 = ref_op(DIV, a1, b1, m_hl);
    exp2 = ref_op(MULT, a2, b2, exp1);
    @(negedge Clk); Start = 1'b1; Op = DIV; OpA = a1; OpB = b1;
    @(posedge Clk); #1;
    Op = MULT; OpA = a2; OpB = b2; #1;
    guard = 0; stall_ok = 1;
    while (Busy === 1'b1 && guard < 100) begin
      if (Stall !== 1'b1) stall_ok = 0;
      @(posedge Clk); #1; guard++;
    end
    total++;
    if (!stall_ok || guard != 33 || Done !== 1'b1 || {Hi, Lo} !== exp1) begin
      bad++; $display("FAIL b2b_first: stall_ok=%0d busy_cycles=%0d done=%b hilo=%h, want 1/33/1/%h",
                      stall_ok, guard, Done, {Hi, Lo}, exp1);
    end
    @(posedge Clk); #1; Start = 1'b0;
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge Clk); #1; lat++;
    end
    total++;
    if (lat != LAT_MUL || {Hi, Lo} !== exp2) begin
      bad++; $display("FAIL b2b_second: lat=%0d hilo=%h, want %0d and %h", lat, {Hi, Lo}, LAT_MUL, exp2);
    end
    m_hl = exp2;
  endtask

  task automatic test_flush();
    logic [63:0] exp_hl;
    logic [31:0] a, b;
    int lat;
    @(negedge Clk); Start = 1'b1; Flush = 1'b1; Op = MTHI; OpA = $urandom;
    @(posedge Clk); #1;
    total++;
    if ({Hi, Lo} !== m_hl || Busy !== 1'b0) begin
      bad++; $display("FAIL flush_move: hilo=%h busy=%b, want %h and 0", {Hi, Lo}, Busy, m_hl);
    end
    Op = DIV; OpB = 32'd3;
    @(posedge Clk); #1;
    total++;
    if (Busy !== 1'b0) begin
      bad++; $display("FAIL flush_start: busy=%b, want 0", Busy);
    end
    Start = 1'b0; Flush = 1'b0;
    a = $urandom; b = $urandom_range(1, 1 << 20);
    exp_hl = ref_op(DIVU, a, b, m_hl);
    @(negedge Clk); Start = 1'b1; Op = DIVU; OpA = a; OpB = b;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1; Flush = 1'b1;
    repeat (3) @(posedge Clk);
    #1; Flush = 1'b0;
    lat = 8;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge Clk); #1; lat++;
    end
    total++;
    if (lat != LAT_ITER || {Hi, Lo} !== exp_hl) begin
      bad++; $display("FAIL flush_busy: lat=%0d hilo=%h, want %0d and %h", lat, {Hi, Lo}, LAT_ITER, exp_hl);
    end
    m_hl = exp_hl;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b;
    int sel;
    repeat (40) begin
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 5);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 1000);
      else if (sel == 3) a = -($urandom_range(1, 100000));
      run_op(op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_read();
    test_back_to_back();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
